bist_controller: RTL
====================

# bist_controller

Sequencing FSM for logic BIST on the s9234 scan core. Sits directly upstream of the scan/BIST wrapper: it drives `scan_en`, `bist_en`, `TPG_reset` and `COMP_reset` on the wrapper, and supplies the clock enable for the signature compactor. It runs a fixed number of shift/capture patterns, unloads the last response, compares the 7-bit compactor signature against a golden value, and reports pass/fail.

## Interface
Parameters:
- `CHAIN_LEN`, 33: shift cycles per pattern, equal to the longest scan chain.
- `NUM_PATTERNS`, 100: number of capture cycles; must be at least 1.
- `GOLDEN_SIG`, 7'h00: expected compactor signature.

Ports (clock `CK`, reset `reset`; reset is asynchronous and active-high):
- `CK`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; forces IDLE.
- `start`  in  1  level; sampled only in IDLE.
- `signature`  in  7  compactor `q`.
- `scan_en`  out  1  scan shift enable to the wrapper.
- `bist_en`  out  1  TPG clock gate and SI mux select.
- `tpg_reset`  out  1  to `TPG_reset`.
- `comp_reset`  out  1  to `COMP_reset`.
- `comp_en`  out  1  compactor clock enable; gated as `comp_en & CK`.
- `busy`  out  1  high in any state except IDLE and DONE.
- `done`  out  1  high in DONE.
- `pass`  out  1  compare result; valid while `done` is high.

## Operation
- States: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
- IDLE -> INIT when `start`=1.
- INIT: 1 cycle. `tpg_reset`=`comp_reset`=1, `bist_en`=1, so the synchronous resets take effect. Then -> SHIFT.
- SHIFT: `CHAIN_LEN` cycles with `scan_en`=`bist_en`=1.
  - `comp_en`=1 except during the first pattern's load, where chain contents are unknown.
  - Shift counter counts 0..CHAIN_LEN-1, then -> CAPTURE.
- CAPTURE: 1 cycle. `scan_en`=`bist_en`=`comp_en`=0, so the TPG and compactor hold. Pattern counter increments.
  - If count == NUM_PATTERNS -> UNLOAD; else -> SHIFT.
- UNLOAD: `CHAIN_LEN` cycles with `scan_en`=`bist_en`=`comp_en`=1. Then -> COMPARE.
- COMPARE: 1 cycle. `pass` is registered as (`signature`==GOLDEN_SIG). Then -> DONE.
- DONE: `done`=1 and `pass` held. -> IDLE when `start`=0.
- `start` is ignored outside IDLE and DONE.
- Counter widths are $clog2(CHAIN_LEN+1) and $clog2(NUM_PATTERNS+1). Counters clear on entry to SHIFT/UNLOAD and INIT respectively; no wrap occurs.
- Reset value of every output: 0. State after reset: IDLE.

## Timing
- All outputs are registered and decoded from the next state. They change only at the CK rising edge, except `bist_en` and `comp_en`.
- `bist_en` and `comp_en` are retimed through negedge CK flops, so they change half a cycle later. This keeps the AND-gated clocks in the TPG and compactor glitch-free.
- With `start` sampled at edge k:
  - INIT follows edge k.
  - First SHIFT cycle follows edge k+1.
  - CAPTURE of pattern p (1-based) follows edge k+p·(CHAIN_LEN+1).
  - `done` rises after edge k+2+NUM_PATTERNS·(CHAIN_LEN+1)+CHAIN_LEN. With default parameters this is k+3435.
- Reset asserted mid-run: all outputs drop to 0 asynchronously and the FSM enters IDLE. The next run requires `start` again.
- `start` held high through DONE: the FSM stays in DONE; there is no auto-restart.

## Configuration
- `BIST_SIG_LATCH_EN` defined: adds output `sig_q` [6:0], reset value 0. It latches `signature` in COMPARE and holds it through DONE for diagnosis.
- `BIST_SIG_LATCH_EN` undefined: the port and register are absent. `pass` is the only result.

## Test plan
All scenarios use CHAIN_LEN=4, NUM_PATTERNS=3.
- Reset then idle: all outputs are 0; `start`=0 for 10 cycles gives no change.
- `start` pulse at edge k:
  - INIT with `tpg_reset`=`comp_reset`=1 after k.
  - `scan_en` high for 4 cycles, low for 1 (×3), then 4 UNLOAD cycles.
  - `done`=1 after edge k+21.
- `comp_en` pattern: 0 during the first 4 SHIFT cycles, 1 during later SHIFT and UNLOAD cycles, 0 in CAPTURE. Rising and falling transitions land on the negedge of CK.
- GOLDEN_SIG=7'h5A with `signature` driven 7'h5A gives `pass`=1. Driving 7'h5B gives `pass`=0. With the macro defined, `sig_q` equals the driven value.
- `reset` asserted during the second SHIFT: outputs are 0 immediately and the state is IDLE. A new `start` reproduces the full 21-cycle sequence.
- `start` held high through DONE: `done` stays 1. Dropping `start` gives `done`=0 and `busy`=0 the next cycle.

Source files
------------

// File: rtl/bist_controller.sv
// Logic BIST sequencer for the s9234 scan core: INIT, shift/capture loop, unload, compare.
// Optional BIST_SIG_LATCH_EN adds sig_q, the signature latched in COMPARE.
module bist_controller #(
    parameter int         CHAIN_LEN    = 33,
    parameter int         NUM_PATTERNS = 100,
    parameter logic [6:0] GOLDEN_SIG   = 7'h00
) (
    input  logic       CK,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] signature,
    output logic       scan_en,
    output logic       bist_en,
    output logic       tpg_reset,
    output logic       comp_reset,
    output logic       comp_en,
    output logic       busy,
    output logic       done,
`ifdef BIST_SIG_LATCH_EN
    output logic [6:0] sig_q,
`endif
    output logic       pass
);

    localparam int SW = $clog2(CHAIN_LEN + 1);
    localparam int PW = $clog2(NUM_PATTERNS + 1);

    typedef enum logic [2:0] {
        IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [SW-1:0] scnt;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nxt;
    logic          last_shift;
    logic          bist_q;
    logic          comp_q;

    assign last_shift = (scnt == SW'(CHAIN_LEN - 1));

    always_comb begin
        nxt      = state;
        pcnt_nxt = pcnt;
        unique case (state)
            IDLE:    if (start) nxt = INIT;
            INIT: begin
                nxt      = SHIFT;
                pcnt_nxt = '0;
            end
            SHIFT:   if (last_shift) nxt = CAPTURE;
            CAPTURE: begin
                pcnt_nxt = pcnt + 1'b1;
                nxt = (pcnt_nxt == PW'(NUM_PATTERNS)) ? UNLOAD : SHIFT;
            end
            UNLOAD:  if (last_shift) nxt = COMPARE;
            COMPARE: nxt = DONE;
            DONE:    if (!start) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            scnt       <= '0;
            pcnt       <= '0;
            scan_en    <= 1'b0;
            bist_q     <= 1'b0;
            comp_q     <= 1'b0;
            tpg_reset  <= 1'b0;
            comp_reset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
`ifdef BIST_SIG_LATCH_EN
            sig_q      <= '0;
`endif
        end else begin
            state <= nxt;
            pcnt  <= pcnt_nxt;
            if ((state == SHIFT || state == UNLOAD) && nxt == state)
                scnt <= scnt + 1'b1;
            else
                scnt <= '0;
            scan_en    <= (nxt == SHIFT) || (nxt == UNLOAD);
            bist_q     <= (nxt == INIT) || (nxt == SHIFT) || (nxt == UNLOAD);
            // the first pattern's load shifts unknown chain data: keep it out of the compactor
            comp_q     <= (nxt == UNLOAD) || (nxt == SHIFT && pcnt_nxt != '0);
            tpg_reset  <= (nxt == INIT);
            comp_reset <= (nxt == INIT);
            busy       <= (nxt != IDLE) && (nxt != DONE);
            done       <= (nxt == DONE);
            if (state == COMPARE)
                pass <= (signature == GOLDEN_SIG);
            else if (nxt == IDLE)
                pass <= 1'b0;
`ifdef BIST_SIG_LATCH_EN
            if (state == COMPARE)
                sig_q <= signature;
`endif
        end
    end

    // half-cycle retime keeps the AND-gated TPG/compactor clocks glitch-free
    always_ff @(negedge CK or posedge reset) begin
        if (reset) begin
            bist_en <= 1'b0;
            comp_en <= 1'b0;
        end else begin
            bist_en <= bist_q;
            comp_en <= comp_q;
        end
    end

endmodule
